apb_timer_slave: RTL and testbench



---
 rtl/apb_timer_pkg.sv | 15 +
 rtl/apb_timer_slave_if.sv | 14 +
 rtl/apb_timer_core.sv | 60 ++++++
 rtl/apb_timer_slave.sv | 128 ++++++++++++
 tb/tb_apb_timer_slave.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer slave: register byte offsets and CTRL field positions.
package apb_timer_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'h00;
    localparam logic [4:0] ADDR_LOAD    = 5'h04;
    localparam logic [4:0] ADDR_COUNT   = 5'h08;
    localparam logic [4:0] ADDR_STATUS  = 5'h0C;
    localparam logic [4:0] ADDR_SCRATCH = 5'h10;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_PSC = 3;

endpackage

// File: rtl/apb_timer_slave_if.sv
// APB signals between the bridge and one timer slave.
interface apb_timer_slave_if;

    logic        Penable;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (output Penable, Pwrite, Pselx, Paddr, Pwdata, input Prdata);
    modport slave  (input Penable, Pwrite, Pselx, Paddr, Pwdata, output Prdata);

endinterface

// File: rtl/apb_timer_core.sv
// Prescaler, down-counter and expiry detection; register decode lives in the top level.
module apb_timer_core #(
    parameter int PSC_W = 8
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             en_i,
    input  logic             auto_reload_i,
    input  logic [PSC_W-1:0] psc_i,
    input  logic [31:0]      reload_i,
    input  logic             load_i,
    input  logic [31:0]      load_val_i,
    input  logic             start_i,
    output logic [31:0]      count_o,
    output logic             expire_o,
    output logic             stop_o
);

    logic [PSC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]      count_q, count_d;
    logic             tick;

    assign tick    = en_i && (pcnt_q == psc_i);
    assign count_o = count_q;

    always_comb begin
        pcnt_d   = pcnt_q;
        count_d  = count_q;
        expire_o = 1'b0;
        stop_o   = 1'b0;

        if (!en_i || start_i || tick) pcnt_d = '0;
        else                          pcnt_d = pcnt_q + 1'b1;

        // A software load restarts the period and swallows any coincident tick.
        if (load_i) begin
            count_d = load_val_i;
            pcnt_d  = '0;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire_o = 1'b1;
                if (auto_reload_i) count_d = reload_i;
                else               stop_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pcnt_q  <= '0;
            count_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB-mapped down-counting timer with prescaler, reload, sticky expiry, level irq and a scratch register.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int SEL_IDX = 0,
    parameter int PSC_W   = 8
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    apb_timer_slave_if.slave  bus,
    output logic              irq
);

    logic             sel, wr;
    logic [4:0]       off;
    logic             wr_ctrl, wr_load, wr_status, wr_scratch;
    logic             en_q, en_d, ar_q, ar_d, ie_q, ie_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [31:0]      load_q, load_d, scratch_q, scratch_d;
    logic             expired_q, expired_d, irq_q, irq_d;
    logic             start, expire, stop;
    logic [31:0]      count, ctrl_rd, rdata;
    logic             unused_ok;

    assign sel = bus.Pselx[SEL_IDX];
    assign wr  = sel && bus.Penable && bus.Pwrite;
    assign off = {bus.Paddr[4:2], 2'b00};

    assign wr_ctrl    = wr && (off == ADDR_CTRL);
    assign wr_load    = wr && (off == ADDR_LOAD);
    assign wr_status  = wr && (off == ADDR_STATUS);
    assign wr_scratch = wr && (off == ADDR_SCRATCH);

    assign start     = wr_ctrl && bus.Pwdata[CTRL_EN] && !en_q;
    assign unused_ok = ^{bus.Paddr[31:5], bus.Paddr[1:0]};

    apb_timer_core #(.PSC_W(PSC_W)) u_core (
        .Hclk          (Hclk),
        .Hresetn       (Hresetn),
        .en_i          (en_q),
        .auto_reload_i (ar_q),
        .psc_i         (psc_q),
        .reload_i      (load_q),
        .load_i        (wr_load),
        .load_val_i    (bus.Pwdata),
        .start_i       (start),
        .count_o       (count),
        .expire_o      (expire),
        .stop_o        (stop)
    );

    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        ie_d      = ie_q;
        psc_d     = psc_q;
        load_d    = load_q;
        scratch_d = scratch_q;
        expired_d = expired_q;

        // Software CTRL write beats the one-shot auto-clear of en.
        if (wr_ctrl) begin
            en_d  = bus.Pwdata[CTRL_EN];
            ar_d  = bus.Pwdata[CTRL_AR];
            ie_d  = bus.Pwdata[CTRL_IE];
            psc_d = bus.Pwdata[CTRL_PSC +: PSC_W];
        end else if (stop) begin
            en_d  = 1'b0;
        end
        if (wr_load)    load_d    = bus.Pwdata;
        if (wr_scratch) scratch_d = bus.Pwdata;

        // A fresh expiry beats a W1C in the same cycle.
        if (expire)                         expired_d = 1'b1;
        else if (wr_status && bus.Pwdata[0]) expired_d = 1'b0;

        irq_d = expired_d && ie_d;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            psc_q     <= '0;
            load_q    <= '0;
            scratch_q <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            ie_q      <= ie_d;
            psc_q     <= psc_d;
            load_q    <= load_d;
            scratch_q <= scratch_d;
            expired_q <= expired_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        ctrl_rd                       = '0;
        ctrl_rd[CTRL_EN]              = en_q;
        ctrl_rd[CTRL_AR]              = ar_q;
        ctrl_rd[CTRL_IE]              = ie_q;
        ctrl_rd[CTRL_PSC +: PSC_W]    = psc_q;
    end

    always_comb begin
        rdata = '0;
        if (sel && !bus.Pwrite) begin
            case (off)
                ADDR_CTRL:    rdata = ctrl_rd;
                ADDR_LOAD:    rdata = load_q;
                ADDR_COUNT:   rdata = count;
                ADDR_STATUS:  rdata = {31'd0, expired_q};
                ADDR_SCRATCH: rdata = scratch_q;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.Prdata = rdata;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave (SEL_IDX=1, PSC_W=8).
module tb_apb_timer_slave;

    localparam logic [2:0]  SEL   = 3'b010;
    localparam logic [31:0] A_CTRL = 32'h00, A_LOAD = 32'h04, A_COUNT = 32'h08,
                            A_STAT = 32'h0C, A_SCR  = 32'h10;

    logic Hclk, Hresetn, irq;
    int   checks, errors;
    logic [31:0] d;

    apb_timer_slave_if bus ();

    apb_timer_slave #(.SEL_IDX(1), .PSC_W(8)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus),
        .irq     (irq)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Setup now, access phase after the next edge, commit on the edge after that.
    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [2:0] s);
        bus.Pselx = s; bus.Pwrite = 1'b1; bus.Penable = 1'b0; bus.Paddr = a; bus.Pwdata = v;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
        bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s, output logic [31:0] v);
        bus.Pselx = s; bus.Pwrite = 1'b0; bus.Penable = 1'b0; bus.Paddr = a;
        #1;
        v = bus.Prdata;
        bus.Pselx = 3'b000;
    endtask

    task automatic tick1;
        @(posedge Hclk); #1;
    endtask

    task automatic test_reset;
        rd(A_CTRL, SEL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL por_ctrl got %h exp 0", d); end
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL por_count got %h exp 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL por_irq got %b exp 0", irq); end
        // Make expired=1 via a zero-length one-shot, then park COUNT at 5 with a slow prescaler.
        wr(A_LOAD, 32'd0, SEL);
        wr(A_CTRL, 32'h5, SEL);
        tick1;
        wr(A_LOAD, 32'd5, SEL);
        wr(A_CTRL, 32'h7FF, SEL);
        wr(A_SCR, 32'h1234_5678, SEL);
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL pre_rst_count got %h exp 5", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got %b exp 1", irq); end
        @(posedge Hclk); #3;
        Hresetn = 1'b0;
        #1;
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", d); end
        rd(A_STAT, SEL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", d); end
        rd(A_CTRL, SEL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", d); end
        rd(A_SCR, SEL, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h exp 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        repeat (5) tick1;
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_rst_count got %h exp 0", d); end
        rd(A_CTRL, SEL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_rst_ctrl got %h exp 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_rst_irq got %b exp 0", irq); end
    endtask

    task automatic test_regs;
        wr(A_SCR, 32'hDEAD_BEEF, SEL);
        rd(A_SCR, SEL, d); checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch got %h exp deadbeef", d); end
        wr(32'h14, 32'hFFFF_FFFF, SEL);
        rd(32'h18, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped18 got %h exp 0", d); end
        rd(32'h14, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped14 got %h exp 0", d); end
        wr(A_LOAD, 32'h77, SEL);
        wr(A_COUNT, 32'h55, SEL);
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h77) begin errors++; $display("FAIL count_ro got %h exp 77", d); end
        rd(A_LOAD, SEL, d);  checks++; if (d !== 32'h77) begin errors++; $display("FAIL load_rb got %h exp 77", d); end
    endtask

    task automatic test_oneshot;
        logic [31:0] exp_cnt;
        wr(A_LOAD, 32'd3, SEL);
        wr(A_CTRL, 32'h5, SEL);
        for (int i = 0; i < 4; i++) begin
            exp_cnt = 32'd3 - 32'(i);
            rd(A_COUNT, SEL, d);
            checks++; if (d !== exp_cnt) begin errors++; $display("FAIL oneshot_count%0d got %h exp %h", i, d, exp_cnt); end
            rd(A_STAT, SEL, d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_early_exp%0d got %h exp 0", i, d); end
            tick1;
        end
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_expired got %h exp 1", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b exp 1", irq); end
        rd(A_CTRL, SEL, d);  checks++; if (d !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl got %h exp 4", d); end
        tick1;
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_hold got %h exp 0", d); end
        wr(A_STAT, 32'h0, SEL);
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL w0_status got %h exp 1", d); end
        wr(A_STAT, 32'h1, SEL);
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_status got %h exp 0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
    endtask

    // Edge E0 commits CTRL; expiries land on E6, E12, E18.
    task automatic test_autoreload_and_simul;
        wr(A_LOAD, 32'd2, SEL);
        wr(A_CTRL, 32'h0B, SEL);
        repeat (5) tick1;
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ar_e5 got %h exp 0", d); end
        tick1;
        rd(A_STAT, SEL, d);  checks++; if (d !== 32'h1) begin errors++; $display("FAIL ar_e6 got %h exp 1", d); end
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL ar_reload got %h exp 2", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq_masked got %b exp 0", irq); end
        wr(A_STAT, 32'h1, SEL);
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ar_w1c_e8 got %h exp 0", d); end
        repeat (3) tick1;
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ar_e11 got %h exp 0", d); end
        tick1;
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL ar_e12 got %h exp 1", d); end
        wr(A_CTRL, 32'h0F, SEL);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_irq_e14 got %b exp 1", irq); end
        repeat (2) tick1;
        wr(A_STAT, 32'h1, SEL);
        rd(A_STAT, SEL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL simul_expired got %h exp 1", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL simul_irq got %b exp 1", irq); end
    endtask

    task automatic test_pselx;
        wr(A_CTRL, 32'h0, SEL);
        wr(A_LOAD, 32'h1234, 3'b001);
        rd(A_LOAD, SEL, d);    checks++; if (d !== 32'd2) begin errors++; $display("FAIL psel_miss_load got %h exp 2", d); end
        rd(A_LOAD, 3'b001, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL psel_miss_rd got %h exp 0", d); end
        wr(A_LOAD, 32'h1234, 3'b010);
        rd(A_LOAD, SEL, d);  checks++; if (d !== 32'h1234) begin errors++; $display("FAIL psel_hit_load got %h exp 1234", d); end
        rd(A_COUNT, SEL, d); checks++; if (d !== 32'h1234) begin errors++; $display("FAIL psel_hit_count got %h exp 1234", d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        Hresetn = 1'b0;
        bus.Penable = 1'b0; bus.Pwrite = 1'b0; bus.Pselx = 3'b000;
        bus.Paddr = 32'h0; bus.Pwdata = 32'h0;
        repeat (3) @(posedge Hclk);
        #1 Hresetn = 1'b1;
        tick1;
        test_reset;
        test_regs;
        test_oneshot;
        test_autoreload_and_simul;
        test_pselx;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
